// File: rtl/pc_sequencer_if.sv
// Instruction-memory read and execution-unit dispatch bus for the sequencer.
interface pc_sequencer_if;
  logic       Mem_Req;
  logic [3:0] Mem_Addr;
  logic [7:0] Mem_Rdata;
  logic       Mem_Rvalid;
  logic [7:0] Instr;
  logic       Instr_Valid;
  logic       Exec_Done;

  modport master (
    output Mem_Req, Mem_Addr, Instr, Instr_Valid,
    input  Mem_Rdata, Mem_Rvalid, Exec_Done
  );

  modport slave (
    input  Mem_Req, Mem_Addr, Instr, Instr_Valid,
    output Mem_Rdata, Mem_Rvalid, Exec_Done
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer for the 4-bit processor. Sole driver of the
// Program_Counter controls; resolves JMP/JZ/HALT locally and hands every other
// opcode to the execution unit.
module pc_sequencer #(
  parameter logic [3:0] OP_HALT       = 4'hF,
  parameter logic [3:0] OP_JMP        = 4'hE,
  parameter logic [3:0] OP_JZ         = 4'hD,
  parameter int         FETCH_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Run,
  input  logic [3:0]  Pc,
  input  logic        Zero_Flag,
  pc_sequencer_if.master bus,
  output logic        Pc_Enable,
  output logic [3:0]  Pc_Incr,
  output logic [3:0]  Pc_Load_Value,
  output logic        Halted,
  output logic        Fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_HALT, S_FAULT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t     state_q;
  logic [7:0] wait_q;
  logic [7:0] instr_q;
  logic       req_q;
  logic       ivalid_q;
  logic       pc_en_q;
  logic [3:0] pc_incr_q;
  logic [3:0] pc_load_q;
  logic       halted_q;
  logic       fault_q;

  // Address is the live PC; the request strobe qualifies it.
  assign bus.Mem_Addr    = Pc;
  assign bus.Mem_Req     = req_q;
  assign bus.Instr       = instr_q;
  assign bus.Instr_Valid = ivalid_q;
  assign Pc_Enable       = pc_en_q;
  assign Pc_Incr         = pc_incr_q;
  assign Pc_Load_Value   = pc_load_q;
  assign Halted          = halted_q;
  assign Fault           = fault_q;

  // Sequencer FSM; every output is registered against the state being entered,
  // so Mem_Rvalid/Exec_Done never reach an output combinationally.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      wait_q    <= 8'd0;
      instr_q   <= 8'h00;
      req_q     <= 1'b0;
      ivalid_q  <= 1'b0;
      pc_en_q   <= 1'b1;
      pc_incr_q <= 4'd0;
      pc_load_q <= 4'd0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      // PC hold and no dispatch unless the entered state says otherwise.
      ivalid_q  <= 1'b0;
      pc_en_q   <= 1'b1;
      pc_incr_q <= 4'd0;
      case (state_q)
        S_IDLE: begin
          if (Run) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            wait_q  <= 8'd0;
          end
        end
        S_FETCH: begin
          // Read data takes priority over an expiring timeout.
          if (bus.Mem_Rvalid) begin
            instr_q <= bus.Mem_Rdata;
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end else if (wait_q == WAIT_LAST) begin
            req_q   <= 1'b0;
            fault_q <= 1'b1;
            state_q <= S_FAULT;
          end else begin
            wait_q  <= wait_q + 8'd1;
          end
        end
        S_DECODE: begin
          if (instr_q[7:4] == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else if (instr_q[7:4] == OP_JMP) begin
            pc_en_q   <= 1'b0;
            pc_load_q <= instr_q[3:0];
            state_q   <= S_UPDATE;
          end else if (instr_q[7:4] == OP_JZ) begin
            if (Zero_Flag) begin
              pc_en_q   <= 1'b0;
              pc_load_q <= instr_q[3:0];
            end else begin
              pc_incr_q <= 4'd1;
            end
            state_q <= S_UPDATE;
          end else begin
            ivalid_q <= 1'b1;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (bus.Exec_Done) begin
            pc_incr_q <= 4'd1;
            state_q   <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          // Run is only consulted here, so a dropped Run lets the instruction finish.
          if (Run) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            wait_q  <= 8'd0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_HALT:  state_q <= S_HALT;
        S_FAULT: state_q <= S_FAULT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: models the Program_Counter, a 16-byte
// instruction memory with programmable wait states and an execution unit with
// programmable completion delay.
module tb_pc_sequencer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Run;
  logic       Zero_Flag;
  logic [3:0] Pc;
  logic       Pc_Enable;
  logic [3:0] Pc_Incr;
  logic [3:0] Pc_Load_Value;
  logic       Halted;
  logic       Fault;

  pc_sequencer_if bus();

  pc_sequencer dut (
    .Clk(Clk), .Rst(Rst), .Run(Run), .Pc(Pc), .Zero_Flag(Zero_Flag),
    .bus(bus), .Pc_Enable(Pc_Enable), .Pc_Incr(Pc_Incr),
    .Pc_Load_Value(Pc_Load_Value), .Halted(Halted), .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  // Environment models
  logic [7:0] mem [16];
  int rv_delay = 0;
  int rv_never = 0;
  int ed_delay = 0;
  int fw = 0;
  int ecnt = 0;
  int ivc = 0;

  always @(posedge Clk) begin
    if (Rst)                 Pc <= 4'd0;
    else if (Pc_Enable)      Pc <= Pc + Pc_Incr;
    else                     Pc <= Pc_Load_Value;
  end

  always @(posedge Clk) begin
    if (Rst || !bus.Mem_Req) fw <= 0;
    else                     fw <= fw + 1;
  end

  always @(posedge Clk) begin
    if (Rst || bus.Exec_Done)             ecnt <= 0;
    else if (bus.Instr_Valid || ecnt != 0) ecnt <= ecnt + 1;
  end

  always @(posedge Clk) if (bus.Instr_Valid) ivc <= ivc + 1;

  assign bus.Mem_Rdata  = mem[bus.Mem_Addr];
  assign bus.Mem_Rvalid = bus.Mem_Req && (rv_never == 0) && (fw >= rv_delay);
  assign bus.Exec_Done  = (bus.Instr_Valid || ecnt != 0) && (ecnt >= ed_delay);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    Run = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int a = 0; a < 16; a++) mem[a] = v;
  endtask

  typedef struct {
    logic [7:0] m0, m2, m5;
    logic       zf;
    int         ncyc;
    logic [3:0] exp_pc;
    logic       exp_halt;
    int         exp_iv;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int base, k, found, reqs;

    // program, zero flag, cycles after Run rises, expected Pc/Halted/dispatches
    vecs[0] = '{8'h31, 8'h31, 8'h31, 1'b0, 17, 4'd4, 1'b0, 4};
    vecs[1] = '{8'h31, 8'h31, 8'h31, 1'b0, 65, 4'd0, 1'b0, 16};
    vecs[2] = '{8'h31, 8'h31, 8'h31, 1'b0, 69, 4'd1, 1'b0, 17};
    vecs[3] = '{8'hE5, 8'h31, 8'hD9, 1'b1,  4, 4'd5, 1'b0, 0};
    vecs[4] = '{8'hE5, 8'h31, 8'hD9, 1'b1,  7, 4'd9, 1'b0, 0};
    vecs[5] = '{8'hE5, 8'h31, 8'hD9, 1'b0,  7, 4'd6, 1'b0, 0};
    vecs[6] = '{8'h31, 8'hF0, 8'h31, 1'b0, 11, 4'd2, 1'b1, 2};
    vecs[7] = '{8'h31, 8'hF0, 8'h31, 1'b0, 20, 4'd2, 1'b1, 2};

    Rst = 1'b1; Run = 1'b0; Zero_Flag = 1'b0;
    fill_mem(8'h31);

    // Reset and hold with Run low
    do_reset();
    repeat (5) @(negedge Clk);
    chk("rst_pc", 32'(Pc), 32'd0);
    chk("rst_pc_enable", 32'(Pc_Enable), 32'd1);
    chk("rst_pc_incr", 32'(Pc_Incr), 32'd0);
    chk("rst_pc_load", 32'(Pc_Load_Value), 32'd0);
    chk("rst_mem_req", 32'(bus.Mem_Req), 32'd0);
    chk("rst_mem_addr", 32'(bus.Mem_Addr), 32'd0);
    chk("rst_instr", 32'(bus.Instr), 32'h00);
    chk("rst_ivalid", 32'(bus.Instr_Valid), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_fault", 32'(Fault), 32'd0);

    // Table-driven programs
    for (int v = 0; v < 8; v++) begin
      fill_mem(8'h31);
      mem[0] = vecs[v].m0; mem[2] = vecs[v].m2; mem[5] = vecs[v].m5;
      Zero_Flag = vecs[v].zf;
      rv_delay = 0; rv_never = 0; ed_delay = 0;
      do_reset();
      base = ivc;
      Run = 1'b1;
      repeat (vecs[v].ncyc) @(negedge Clk);
      chk($sformatf("vec%0d_pc", v), 32'(Pc), 32'(vecs[v].exp_pc));
      chk($sformatf("vec%0d_halted", v), 32'(Halted), 32'(vecs[v].exp_halt));
      chk($sformatf("vec%0d_ivalid_count", v), 32'(ivc - base), 32'(vecs[v].exp_iv));
    end

    // Halt is sticky against Run toggling; Rst clears it
    for (int t = 0; t < 6; t++) begin
      Run = ~Run;
      @(negedge Clk);
    end
    chk("halt_sticky", 32'(Halted), 32'd1);
    chk("halt_pc_held", 32'(Pc), 32'd2);
    chk("halt_no_req", 32'(bus.Mem_Req), 32'd0);
    chk("halt_pc_enable", 32'(Pc_Enable), 32'd1);
    do_reset();
    @(negedge Clk);
    chk("halt_rst_cleared", 32'(Halted), 32'd0);
    chk("halt_rst_instr", 32'(bus.Instr), 32'h00);
    chk("halt_rst_req", 32'(bus.Mem_Req), 32'd0);

    // Three wait states: request held for four cycles, then the byte latches
    fill_mem(8'h31);
    mem[0] = 8'h42;
    rv_delay = 3;
    do_reset();
    Run = 1'b1;
    reqs = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge Clk);
      if (bus.Mem_Req) reqs++;
      if (c == 5) chk("wait_instr_latched", 32'(bus.Instr), 32'h42);
    end
    chk("wait_req_cycles", 32'(reqs), 32'd4);

    // Read data on the last permitted cycle beats the timeout
    rv_delay = 14;
    do_reset();
    Run = 1'b1;
    repeat (17) @(negedge Clk);
    chk("edge_rvalid_no_fault", 32'(Fault), 32'd0);
    chk("edge_rvalid_instr", 32'(bus.Instr), 32'h42);

    // No read data: fault 15 cycles after FETCH entry
    rv_never = 1;
    do_reset();
    Run = 1'b1;
    @(negedge Clk);
    found = -1;
    for (k = 1; k <= 40; k++) begin
      @(negedge Clk);
      if (Fault) begin
        found = k;
        break;
      end
    end
    chk("timeout_cycles", 32'(found), 32'd15);
    chk("timeout_no_req", 32'(bus.Mem_Req), 32'd0);
    Run = 1'b0;
    repeat (3) @(negedge Clk);
    Run = 1'b1;
    repeat (3) @(negedge Clk);
    chk("fault_sticky", 32'(Fault), 32'd1);
    chk("fault_pc_held", 32'(Pc), 32'd0);
    do_reset();
    @(negedge Clk);
    chk("fault_rst_cleared", 32'(Fault), 32'd0);
    rv_never = 0;
    rv_delay = 0;

    // Run drops during a slow EXEC: instruction completes, block parks in IDLE
    fill_mem(8'h31);
    ed_delay = 6;
    do_reset();
    base = ivc;
    Run = 1'b1;
    repeat (3) @(negedge Clk);
    chk("slow_ivalid_first_exec", 32'(bus.Instr_Valid), 32'd1);
    Run = 1'b0;
    @(negedge Clk);
    chk("slow_ivalid_one_cycle", 32'(bus.Instr_Valid), 32'd0);
    repeat (11) @(negedge Clk);
    chk("slow_pc_once", 32'(Pc), 32'd1);
    chk("slow_parked_no_req", 32'(bus.Mem_Req), 32'd0);
    chk("slow_ivalid_count", 32'(ivc - base), 32'd1);
    Run = 1'b1;
    @(negedge Clk);
    chk("resume_req", 32'(bus.Mem_Req), 32'd1);
    chk("resume_addr", 32'(bus.Mem_Addr), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
